// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per cycle,
// 64-bit HI/LO result through a start/busy/done handshake.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state, state_nxt;
  logic             is_div, sign_q, sign_r;
  logic [WIDTH-1:0] opb, p_hi, p_lo;
  logic [CW-1:0]    count;

  logic             a_neg, b_neg, b_zero, accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

  // op[0]=0 selects the signed variants
  assign a_neg  = ~op[0] & portA[WIDTH-1];
  assign b_neg  = ~op[0] & portB[WIDTH-1];
  assign a_mag  = a_neg ? -portA : portA;
  assign b_mag  = b_neg ? -portB : portB;
  assign b_zero = (portB == '0);
  assign accept = (state == S_IDLE || state == S_DONE) && start && !flush;

  // opb holds multiplicand (MUL) or divisor (DIV); p_lo holds multiplier or dividend/quotient
  assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opb} : '0);
  assign div_shift = {p_hi, p_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  assign div_ok    = ~div_diff[WIDTH];

  assign prod     = {p_hi, p_lo};
  assign prod_fix = sign_q ? -prod : prod;
  assign q_fix    = sign_q ? -p_lo : p_lo;
  assign r_fix    = sign_r ? -p_hi : p_hi;

  assign busy = (state == S_CALC) || (state == S_FIX);
  assign done = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (flush || !start) state_nxt = S_IDLE;
        else if (op[1] && b_zero) state_nxt = S_DONE;
        else state_nxt = S_CALC;
      end
      S_CALC: begin
        if (flush) state_nxt = S_IDLE;
        else if (count == LAST) state_nxt = S_FIX;
      end
      S_FIX: state_nxt = flush ? S_IDLE : S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      is_div      <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      opb         <= '0;
      p_hi        <= '0;
      p_lo        <= '0;
      count       <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            is_div <= op[1];
            sign_q <= a_neg ^ b_neg;
            sign_r <= a_neg;
            count  <= '0;
            p_hi   <= '0;
            opb    <= op[1] ? b_mag : a_mag;
            p_lo   <= op[1] ? a_mag : b_mag;
            if (op[1] && b_zero) begin
              hi          <= portA;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end
          end
        end
        S_CALC: begin
          if (!flush) begin
            count <= count + CW'(1);
            if (is_div) begin
              p_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
              p_lo <= {p_lo[WIDTH-2:0], div_ok};
            end else begin
              p_hi <= mul_sum[WIDTH:1];
              p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
            end
          end
        end
        S_FIX: begin
          if (!flush) begin
            div_by_zero <= 1'b0;
            if (is_div) begin
              hi <= r_fix;
              lo <= q_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results queued at start, compared at done.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] portA = '0, portB = '0;
  logic         flush = 1'b0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .op(op), .portA(portA), .portB(portB),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [W-1:0] last_hi = '0, last_lo = '0;

  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    longint sa, sbv, q, r;
    logic [63:0] p;
    z = 1'b0; h = '0; l = '0;
    case (o)
      2'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        h = p[63:32]; l = p[31:0];
      end
      2'd1: begin
        p = {32'b0, a} * {32'b0, b};
        h = p[63:32]; l = p[31:0];
      end
      2'd2: begin
        if (b == '0) begin z = 1'b1; h = a; l = '1; end
        else begin
          sa = longint'($signed(a)); sbv = longint'($signed(b));
          q = sa / sbv; r = sa % sbv;
          l = q[31:0]; h = r[31:0];
        end
      end
      default: begin
        if (b == '0) begin z = 1'b1; h = a; l = '1; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  // Drives one start cycle; returns at the negedge after the start edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic ez,
                       input bit now, input bit push);
    exp_t e;
    if (!now) @(negedge CLK);
    start = 1'b1; op = o; portA = a; portB = b;
    if (push) begin
      e.hi = eh; e.lo = el; e.dbz = ez; e.lat = ez ? 0 : W + 1;
      sb.push_back(e);
    end
    @(negedge CLK);
    start = 1'b0;
    op = 2'($urandom); portA = $urandom; portB = $urandom;
  endtask

  task automatic issue_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit now);
    logic [W-1:0] eh, el;
    logic ez;
    model(o, a, b, eh, el, ez);
    issue(o, a, b, eh, el, ez, now, 1'b1);
  endtask

  // Waits for done (bounded), pops the scoreboard and compares; returns at the done negedge.
  task automatic collect(input string name, input bit noisy);
    exp_t e;
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      if (noisy && n == 4) begin
        start = 1'b1; op = 2'($urandom); portA = $urandom; portB = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge CLK);
      n++;
    end
    start = 1'b0;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s timeout: done got %b want 1 within 100 cycles", name, done);
      return;
    end
    if (n != e.lat) begin
      failures++;
      $display("FAIL %s latency got %0d want %0d", name, n, e.lat);
    end
    checks++;
    if (hi !== e.hi) begin
      failures++;
      $display("FAIL %s hi got %h want %h", name, hi, e.hi);
    end
    checks++;
    if (lo !== e.lo) begin
      failures++;
      $display("FAIL %s lo got %h want %h", name, lo, e.lo);
    end
    checks++;
    if (div_by_zero !== e.dbz) begin
      failures++;
      $display("FAIL %s div_by_zero got %b want %b", name, div_by_zero, e.dbz);
    end
    last_hi = e.hi; last_lo = e.lo;
  endtask

  task automatic test_reset();
    nRST = 1'b0; start = 1'b1; op = 2'd1; portA = 32'h1234; portB = 32'h5;
    repeat (3) @(negedge CLK);
    checks++;
    if ({busy, done, div_by_zero, hi, lo} !== '0) begin
      failures++;
      $display("FAIL reset outputs got busy=%b done=%b dbz=%b hi=%h lo=%h want all 0",
               busy, done, div_by_zero, hi, lo);
    end
    start = 1'b0;
    nRST = 1'b1;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_mul();
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mul_busy got %b want 1", busy);
    end
    collect("multu_max", 1'b1);
    @(negedge CLK);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse got %b want 0", done);
    end
    issue(2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b1);
    collect("mult_neg", 1'b0);
    issue(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 1'b0, 1'b1);
    collect("mult_minmin", 1'b0);
    for (int i = 0; i < 4; i++) begin
      issue_model(2'(i & 1), $urandom, $urandom, 1'b0);
      collect("mul_rand", i == 2);
    end
  endtask

  task automatic test_div();
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b1);
    collect("div_neg", 1'b0);
    issue(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 1'b1);
    collect("divu_100_7", 1'b0);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    collect("div_overflow", 1'b0);
    issue_model(2'd2, 32'd7, 32'hFFFF_FFFE, 1'b0);
    collect("div_negdivisor", 1'b0);
    for (int i = 0; i < 4; i++) begin
      issue_model(2'(2 + (i & 1)), $urandom, $urandom | 32'h1, 1'b0);
      collect("div_rand", 1'b0);
    end
    issue_model(2'd3, $urandom, 32'($urandom_range(1, 255)), 1'b0);
    collect("divu_small", 1'b0);
  endtask

  task automatic test_div_zero();
    issue(2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    collect("divu_zero", 1'b0);
    issue(2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    collect("div_zero_signed", 1'b0);
    issue(2'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0, 1'b1);
    collect("dbz_cleared", 1'b0);
  endtask

  task automatic test_flush();
    issue(2'd0, 32'h1234_5678, 32'h0BAD_F00D, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (9) @(negedge CLK);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL flush_pre_busy got %b want 1", busy);
    end
    flush = 1'b1;
    start = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== last_hi || lo !== last_lo) begin
      failures++;
      $display("FAIL flush_abort got busy=%b done=%b hi=%h lo=%h want 0 0 %h %h",
               busy, done, hi, lo, last_hi, last_lo);
    end
    issue(2'd2, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 1'b1, 1'b1);
    collect("flush_then_div", 1'b0);
    @(negedge CLK);
    start = 1'b1; flush = 1'b1; op = 2'd1; portA = 32'd3; portB = 32'd3;
    @(negedge CLK);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_drops_start got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    issue_model(2'd1, $urandom, $urandom, 1'b0);
    collect("b2b_first", 1'b0);
    issue_model(2'd2, $urandom, $urandom | 32'h100, 1'b1);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_busy got busy=%b done=%b want 1 0", busy, done);
    end
    collect("b2b_second", 1'b0);
    issue_model(2'd3, 32'd77, 32'd0, 1'b1);
    collect("b2b_dbz", 1'b0);
  endtask

  task automatic test_reset_mid();
    issue(2'd0, 32'hCAFE_0001, 32'h0000_0003, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge CLK);
    nRST = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_by_zero, hi, lo} !== '0) begin
      failures++;
      $display("FAIL reset_mid got busy=%b done=%b dbz=%b hi=%h lo=%h want all 0",
               busy, done, div_by_zero, hi, lo);
    end
    @(negedge CLK);
    nRST = 1'b1;
    last_hi = '0; last_lo = '0;
    issue(2'd3, 32'd100, 32'd10, 32'd0, 32'd10, 1'b0, 1'b0, 1'b1);
    collect("after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
